// File: rtl/pingpong_mc_buffer.sv
// Multi-channel ping-pong buffer: per channel one bank is filled while the other drains.
// Banks swap when the write bank is full, or early on a global switch pulse.
module pingpong_mc_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 switch,
    input  logic                 flush,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH-1:0]       bank_sel
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_SEAL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t          state_q, state_d;
        logic            bank_q, bank_d;
        logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
        logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]   rd_len_q, rd_len_d;
        logic            rd_bank_q, rd_bank_d;
        logic            rd_active_q, rd_active_d;

        logic            in_ready_c;
        logic            wr_en_c;
        logic            wr_bank_c;
        logic [AW-1:0]   wr_addr_c;
        logic            rd_hs_c;
        logic            rd_last_c;
        logic            swap_ok_c;

        logic [WIDTH-1:0] mem [2][DEPTH];

        assign rd_hs_c   = rd_active_q & out_ready[c];
        assign rd_last_c = rd_hs_c & (rd_ptr_q == rd_len_q - CW'(1));
        // Read side can take a new bank this edge: idle, or handing over its last word.
        assign swap_ok_c = ~rd_active_q | rd_last_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= S_FILL;
                bank_q      <= 1'b0;
                wr_cnt_q    <= '0;
                rd_ptr_q    <= '0;
                rd_len_q    <= '0;
                rd_bank_q   <= 1'b0;
                rd_active_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                bank_q      <= bank_d;
                wr_cnt_q    <= wr_cnt_d;
                rd_ptr_q    <= rd_ptr_d;
                rd_len_q    <= rd_len_d;
                rd_bank_q   <= rd_bank_d;
                rd_active_q <= rd_active_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            bank_d      = bank_q;
            wr_cnt_d    = wr_cnt_q;
            rd_ptr_d    = rd_ptr_q;
            rd_len_d    = rd_len_q;
            rd_bank_d   = rd_bank_q;
            rd_active_d = rd_active_q;
            in_ready_c  = 1'b0;
            wr_en_c     = 1'b0;
            wr_bank_c   = bank_q;
            wr_addr_c   = AW'(wr_cnt_q);

            if (rd_hs_c) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
                if (rd_last_c) begin
                    rd_active_d = 1'b0;
                end
            end

            unique case (state_q)
                S_FILL: begin
                    in_ready_c = 1'b1;
                    if (in_valid[c]) begin
                        wr_en_c  = 1'b1;
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                    if ((in_valid[c] && (wr_cnt_q == CW'(DEPTH - 1))) ||
                        (switch && ((wr_cnt_q != '0) || in_valid[c]))) begin
                        state_d = S_SEAL;
                    end
                end
                S_SEAL, S_WAIT: begin
                    // During a swapping SEAL cycle the new write bank already accepts word 0.
                    in_ready_c = (state_q == S_SEAL) && swap_ok_c;
                    if (swap_ok_c) begin
                        rd_bank_d   = bank_q;
                        rd_len_d    = wr_cnt_q;
                        rd_ptr_d    = '0;
                        rd_active_d = 1'b1;
                        bank_d      = ~bank_q;
                        wr_cnt_d    = '0;
                        state_d     = S_FILL;
                        if ((state_q == S_SEAL) && in_valid[c]) begin
                            wr_en_c   = 1'b1;
                            wr_bank_c = ~bank_q;
                            wr_addr_c = '0;
                            wr_cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_FILL;
                end
            endcase

            if (flush) begin
                state_d     = S_FILL;
                bank_d      = 1'b0;
                wr_cnt_d    = '0;
                rd_ptr_d    = '0;
                rd_active_d = 1'b0;
                wr_en_c     = 1'b0;
            end
        end

        // Bank storage, intentionally not reset.
        always_ff @(posedge clk) begin
            if (wr_en_c) begin
                mem[wr_bank_c][wr_addr_c] <= in_data[c*WIDTH +: WIDTH];
            end
        end

        assign in_ready[c]                  = in_ready_c;
        assign out_valid[c]                 = rd_active_q;
        assign bank_sel[c]                  = bank_q;
        assign out_data[c*WIDTH +: WIDTH]   = mem[rd_bank_q][AW'(rd_ptr_q)];
    end

endmodule

// File: tb/tb_pingpong_mc_buffer.sv
// Self-checking bench for pingpong_mc_buffer: directed scenarios plus randomized traffic
// checked against a per-channel FIFO scoreboard (words leave in the order they were accepted).
module tb_pingpong_mc_buffer;
    localparam int unsigned W = 16;
    localparam int unsigned D = 8;
    localparam int unsigned N = 2;

    logic           clk;
    logic           rst_n;
    logic           sw;
    logic           fl;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N-1:0]   bank_sel;

    int tests;
    int fails;

    logic [W-1:0] sbq [N][$];
    int           reads [N];
    logic         hold_pend [N];
    logic [W-1:0] hold_data [N];
    logic         ov [40];
    logic         bs [40];

    pingpong_mc_buffer #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switch   (sw),
        .flush    (fl),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bank_sel (bank_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < N; c++) begin
            sbq[c].delete();
            reads[c]     = 0;
            hold_pend[c] = 1'b0;
            hold_data[c] = '0;
        end
    endtask

    // Sample outputs mid-cycle and update the reference model with this cycle's handshakes.
    task automatic sample();
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            logic [W-1:0] d;
            d = out_data[c*W +: W];
            if (hold_pend[c]) begin
                chk("hold_valid", 32'(out_valid[c]), 32'(1));
                chk("hold_data", 32'(d), 32'(hold_data[c]));
            end
            if (out_valid[c]) begin
                chk("rd_pending", 32'(sbq[c].size() > 0), 32'(1));
                if (sbq[c].size() > 0) begin
                    chk("rd_data", 32'(d), 32'(sbq[c][0]));
                    if (out_ready[c] && !fl) begin
                        void'(sbq[c].pop_front());
                        reads[c]++;
                    end
                end
            end
            hold_pend[c] = out_valid[c] && !out_ready[c] && !fl;
            hold_data[c] = d;
            if (in_valid[c] && in_ready[c] && !fl) begin
                sbq[c].push_back(in_data[c*W +: W]);
            end
            if (fl) begin
                sbq[c].delete();
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    // Asserts reset off the clock edge and checks outputs react without waiting for a clock.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        sw        = 1'b0;
        fl        = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(2'b11));
        chk("rst_bank_sel", 32'(bank_sel), 32'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
    endtask

    initial begin
        int first;
        int n;
        int win;
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b1;
        sw       = 1'b0;
        fl       = 1'b0;
        in_data  = '0;
        in_valid = '0;
        out_ready = '0;
        clear_model();
        #1;

        // 1: single full bank, latency and order
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 2'b01;
            in_data[W-1:0] = W'(i);
            sample();
            chk("t1_in_ready", 32'(in_ready[0]), 32'(1));
            chk("t1_no_early_valid", 32'(out_valid[0]), 32'(0));
            advance();
        end
        in_valid = '0;
        sample();
        chk("t1_seal_no_valid", 32'(out_valid[0]), 32'(0));
        chk("t1_bank_before", 32'(bank_sel[0]), 32'(0));
        advance();
        sample();
        chk("t1_valid_latency", 32'(out_valid[0]), 32'(1));
        chk("t1_first_word", 32'(out_data[W-1:0]), 32'(0));
        chk("t1_bank_after", 32'(bank_sel[0]), 32'(1));
        advance();
        repeat (7) cyc();
        sample();
        chk("t1_drained", 32'(out_valid[0]), 32'(0));
        chk("t1_reads", reads[0], 8);
        advance();

        // 2: two back-to-back banks stream without bubbles
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i < 16) ? 2'b01 : 2'b00;
            in_data[W-1:0] = W'(100 + i);
            sample();
            if (i < 16) chk("t2_in_ready", 32'(in_ready[0]), 32'(1));
            ov[i] = out_valid[0];
            bs[i] = bank_sel[0];
            advance();
        end
        first = -1;
        n = 0;
        win = 0;
        for (int i = 0; i < 30; i++) begin
            if (ov[i]) begin
                if (first < 0) first = i;
                n++;
                if (i >= 9 && i <= 24) win++;
            end
        end
        chk("t2_first_valid", first, 9);
        chk("t2_valid_total", n, 16);
        chk("t2_no_bubble", win, 16);
        chk("t2_bank_c8", 32'(bs[8]), 32'(0));
        chk("t2_bank_c9", 32'(bs[9]), 32'(1));
        chk("t2_bank_c17", 32'(bs[17]), 32'(0));
        chk("t2_reads", reads[0], 16);

        // 3: consumer stalled, second sealed bank waits and back-pressures
        do_reset();
        out_ready = '0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 2'b01;
            in_data[W-1:0] = W'(200 + i);
            sample();
            chk("t3_in_ready", 32'(in_ready[0]), 32'(1));
            advance();
        end
        in_data[W-1:0] = W'(216);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_wait_in_ready", 32'(in_ready[0]), 32'(0));
            advance();
        end
        in_valid = '0;
        out_ready = '1;
        repeat (20) cyc();
        sample();
        chk("t3_reads", reads[0], 16);
        chk("t3_in_ready_after", 32'(in_ready[0]), 32'(1));
        chk("t3_drained", 32'(out_valid[0]), 32'(0));
        advance();

        // 4: early switch on a partial bank, and an ignored switch on an empty one
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 2'b01;
            in_data[W-1:0] = W'(300 + i);
            cyc();
        end
        in_valid = '0;
        sw = 1'b1;
        cyc();
        sw = 1'b0;
        repeat (12) cyc();
        chk("t4_reads", reads[0], 3);
        sw = 1'b1;
        cyc();
        sw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t4_empty_switch_valid", 32'(out_valid[0]), 32'(0));
            chk("t4_empty_switch_bank", 32'(bank_sel[0]), 32'(1));
            advance();
        end

        // 5: channel isolation, then flush mid-read
        do_reset();
        out_ready = 2'b10;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 8) ? 2'b11 : 2'b10;
            in_data[W-1:0] = W'(400 + i);
            in_data[W +: W] = W'($urandom);
            sample();
            chk("t5_ch1_in_ready", 32'(in_ready[1]), 32'(1));
            advance();
        end
        in_valid = '0;
        repeat (12) cyc();
        sample();
        chk("t5_ch1_reads", reads[1], 24);
        chk("t5_ch0_stalled_valid", 32'(out_valid[0]), 32'(1));
        chk("t5_ch0_reads", reads[0], 0);
        advance();
        out_ready[0] = 1'b1;
        cyc();
        cyc();
        fl = 1'b1;
        cyc();
        fl = 1'b0;
        sample();
        chk("t5_flush_valid", 32'(out_valid), 32'(0));
        chk("t5_flush_in_ready", 32'(in_ready), 32'(2'b11));
        chk("t5_flush_bank", 32'(bank_sel), 32'(0));
        advance();

        // 6: asynchronous reset mid-drain, then normal operation
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 2'b01;
            in_data[W-1:0] = W'(500 + i);
            cyc();
        end
        in_valid = '0;
        repeat (3) cyc();
        sample();
        chk("t6_mid_drain_valid", 32'(out_valid[0]), 32'(1));
        advance();
        do_reset();
        out_ready = '1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 2'b01;
            in_data[W-1:0] = W'(600 + i);
            cyc();
        end
        in_valid = '0;
        sw = 1'b1;
        cyc();
        sw = 1'b0;
        repeat (10) cyc();
        chk("t6_reads_after_reset", reads[0], 5);

        // Randomized traffic on both channels, then drain
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                in_valid[c]  = ($urandom_range(0, 9) < 7);
                out_ready[c] = ($urandom_range(0, 9) < 6);
                in_data[c*W +: W] = W'($urandom);
            end
            sw = ($urandom_range(0, 15) == 0);
            fl = ($urandom_range(0, 199) == 0);
            cyc();
        end
        fl = 1'b0;
        in_valid = '0;
        out_ready = '1;
        for (int k = 0; k < 60; k++) begin
            sw = (k % 12 == 0);
            cyc();
        end
        sw = 1'b0;
        sample();
        for (int c = 0; c < N; c++) begin
            chk("rand_drain_empty", sbq[c].size(), 0);
            chk("rand_drain_valid", 32'(out_valid[c]), 32'(0));
        end
        advance();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
